// File: rtl/instr_seq_ctrl.sv
// Multi-cycle instruction sequencer for an RV32I core sharing one memory port.
// State and captured instruction fields are registered; controls decode state plus live handshake inputs.
module instr_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLT,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       PCSel,
  output logic       RegWEn,
  output logic       BrUn,
  output logic [2:0] state,
  output logic       retire,
  output logic       illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] op_q;
  logic [2:0] f3_q;

  logic op_legal, is_load, is_store, is_branch, is_jump, br_f3_ok, taken;

  // Legality is judged on the live opcode in DECODE, the same value captured on that edge.
  assign op_legal  = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BRANCH);
  assign is_jump   = (op_q == OP_JAL) || (op_q == OP_JALR);
  assign br_f3_ok  = !(f3_q inside {3'b010, 3'b011});

  always_comb begin
    taken = 1'b0;
    case (f3_q)
      3'b000:         taken = BrEq;
      3'b001:         taken = !BrEq;
      3'b100, 3'b110: taken = BrLT;
      3'b101, 3'b111: taken = !BrLT;
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = op_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_load || is_store) state_d = S_MEM;
        else if (is_branch)      state_d = br_f3_ok ? S_FETCH : S_TRAP;
        else                     state_d = S_WB;
      end
      S_MEM: begin
        if (!mem_ready)    state_d = S_MEM;
        else if (is_store) state_d = S_FETCH;
        else               state_d = S_WB;
      end
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= 7'd0;
      f3_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        f3_q <= funct3;
      end
    end
  end

  // Every control is forced low while reset is held, including the FETCH request.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    PCSel   = 1'b0;
    RegWEn  = 1'b0;
    BrUn    = 1'b0;
    illegal = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        S_EXEC: begin
          if (is_branch) begin
            BrUn  = f3_q[1];
            pc_we = br_f3_ok;
            PCSel = br_f3_ok & taken;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = is_store;
          pc_we   = is_store & mem_ready;
        end
        S_WB: begin
          RegWEn = 1'b1;
          pc_we  = 1'b1;
          PCSel  = is_jump;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign retire = pc_we;
  assign state  = state_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Bench for instr_seq_ctrl: per-instruction expected cycle traces built from the sequencing rules,
// replayed against the DUT with randomized waits, comparator values and junk inputs.
module tb_instr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       BrEq, BrLT, mem_ready;
  logic       mem_req, mem_we, ir_we, pc_we, PCSel, RegWEn, BrUn, retire, illegal;
  logic [2:0] state;

  instr_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .BrEq(BrEq), .BrLT(BrLT), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .PCSel(PCSel), .RegWEn(RegWEn), .BrUn(BrUn), .state(state),
    .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic mem_req, mem_we, ir_we, pc_we, pcsel, regwen, brun, retire, illegal;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       breq, brlt, rdy;
    obs_t       exp;
  } step_t;

  step_t q[$];
  obs_t  act, exp_now;
  logic  chk_en = 1'b0;
  int    total = 0, bad = 0, dut_retires = 0, cyc = 0;

  logic [6:0] legal_tab [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  logic [6:0] bad_tab [4]   = '{7'b1111111, 7'b0000000, 7'b0001111, 7'b1110011};

  assign act = {state, mem_req, mem_we, ir_we, pc_we, PCSel, RegWEn, BrUn, retire, illegal};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic obs_t blank(input logic [2:0] st);
    obs_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic step_t mk(input logic rst, input logic rdy, input logic [6:0] op,
                               input logic [2:0] f3, input logic breq, input logic brlt,
                               input obs_t e);
    step_t s;
    s.rst = rst; s.rdy = rdy; s.op = op; s.f3 = f3; s.breq = breq; s.brlt = brlt; s.exp = e;
    return s;
  endfunction

  // Expected trace for one instruction; len is the cycle count of the instruction itself.
  task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input int fw, input int mw,
                             input logic breq, input logic brlt, input int abort_at, output int len);
    step_t s[$];
    obs_t  e;
    logic  legal, is_ld, is_st, is_br, is_jmp, f3_ok, taken, trapped, aborted;
    legal   = 1'b0;
    foreach (legal_tab[i]) if (legal_tab[i] == op) legal = 1'b1;
    is_ld   = (op == 7'b0000011);
    is_st   = (op == 7'b0100011);
    is_br   = (op == 7'b1100011);
    is_jmp  = (op == 7'b1101111) || (op == 7'b1100111);
    f3_ok   = (f3[2:1] != 2'b01);
    taken   = (f3[2] ? brlt : breq) ^ f3[0];
    trapped = 1'b0;
    aborted = 1'b0;
    for (int i = 0; i <= fw; i++) begin
      e = blank(3'd0); e.mem_req = 1'b1; e.ir_we = (i == fw);
      s.push_back(mk(1'b1, i == fw, 7'($urandom), 3'($urandom), rb(), rb(), e));
    end
    s.push_back(mk(1'b1, rb(), op, f3, rb(), rb(), blank(3'd1)));
    if (!legal) trapped = 1'b1;
    else begin
      e = blank(3'd2);
      if (is_br) begin
        e.brun = f3[1]; e.pc_we = f3_ok; e.retire = f3_ok; e.pcsel = f3_ok & taken;
      end
      s.push_back(mk(1'b1, rb(), 7'($urandom), 3'($urandom), breq, brlt, e));
      if (is_br && !f3_ok) trapped = 1'b1;
      else if (is_ld || is_st) begin
        for (int i = 0; i <= mw; i++) begin
          e = blank(3'd3); e.mem_req = 1'b1; e.mem_we = is_st;
          e.pc_we = is_st && (i == mw); e.retire = e.pc_we;
          s.push_back(mk(1'b1, i == mw, 7'($urandom), 3'($urandom), rb(), rb(), e));
        end
      end
      if (is_ld || (!is_br && !is_st)) begin
        e = blank(3'd4); e.regwen = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1; e.pcsel = is_jmp;
        s.push_back(mk(1'b1, rb(), 7'($urandom), 3'($urandom), rb(), rb(), e));
      end
    end
    len = s.size();
    if (abort_at >= 0 && abort_at < s.size()) begin
      aborted = 1'b1;
      trapped = 1'b0;
      while (s.size() > abort_at) void'(s.pop_back());
    end
    if (trapped) begin
      e = blank(3'd7); e.illegal = 1'b1;
      for (int i = 0; i < 4; i++) s.push_back(mk(1'b1, rb(), 7'($urandom), 3'($urandom), rb(), rb(), e));
    end
    if (trapped || aborted)
      for (int i = 0; i < 2; i++) s.push_back(mk(1'b0, rb(), 7'($urandom), 3'($urandom), rb(), rb(), blank(3'd0)));
    foreach (s[i]) q.push_back(s[i]);
  endtask

  // Single per-cycle compare against the expected trace.
  always @(negedge clk) begin
    if (chk_en) begin
      check($sformatf("cyc%0d", cyc), 32'(act), 32'(exp_now));
      if (act.retire) dut_retires++;
    end
  end

  initial begin
    int len, n_dir, sel, abort;
    logic [6:0] op;
    rst_n = 1'b0; opcode = '0; funct3 = '0; BrEq = 1'b0; BrLT = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) q.push_back(mk(1'b0, 1'b1, 7'd0, 3'd0, 1'b0, 1'b0, blank(3'd0)));

    model_instr(7'b0110011, 3'b000, 0, 0, 1'b0, 1'b0, -1, len);   // ADD
    check("len_add", 32'(len), 32'd4);
    check("add_wb", 32'(q[q.size()-1].exp), 32'h82A);
    model_instr(7'b0000011, 3'b010, 3, 3, 1'b0, 1'b0, -1, len);   // LW with 3+3 waits
    check("len_lw", 32'(len), 32'd11);
    model_instr(7'b1100011, 3'b110, 0, 0, 1'b0, 1'b1, -1, len);   // BLTU taken
    check("len_bltu", 32'(len), 32'd3);
    check("bltu_exec", 32'(q[q.size()-1].exp), 32'h436);
    model_instr(7'b1100011, 3'b101, 0, 0, 1'b0, 1'b1, -1, len);   // BGE not taken
    check("bge_exec", 32'(q[q.size()-1].exp), 32'h422);
    model_instr(7'b1111111, 3'b000, 0, 0, 1'b0, 1'b0, -1, len);   // illegal -> TRAP
    check("len_ill", 32'(len), 32'd2);
    check("trap_val", 32'(q[q.size()-3].exp), 32'hE01);
    model_instr(7'b0100011, 3'b010, 0, 5, 1'b0, 1'b0, 5, len);    // SW reset mid-MEM wait
    check("len_sw", 32'(len), 32'd9);
    model_instr(7'b0100011, 3'b010, 0, 0, 1'b0, 1'b0, -1, len);   // SW after recovery
    check("len_sw0", 32'(len), 32'd4);
    n_dir = q.size();

    for (int n = 0; n < 60; n++) begin
      sel   = $urandom_range(0, 11);
      op    = (sel < 9) ? legal_tab[sel] : bad_tab[$urandom_range(0, 3)];
      abort = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
      model_instr(op, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), rb(), rb(), abort, len);
    end

    for (int k = 0; k < q.size(); k++) begin
      @(posedge clk); #1;
      if (k == n_dir) check("retire_count", 32'(dut_retires), 32'd5);
      rst_n = q[k].rst; opcode = q[k].op; funct3 = q[k].f3;
      BrEq = q[k].breq; BrLT = q[k].brlt; mem_ready = q[k].rdy;
      exp_now = q[k].exp; cyc = k; chk_en = 1'b1;
    end
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_seq_ctrl.md
INSTR_SEQ_CTRL -- requirements
Module: instr_seq_ctrl

Interface
REQ-001 The block SHALL expose the following ports, in this order:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  7  instr[6:0] from the instruction register.
- funct3  input  3  instr[14:12] from the instruction register.
- BrEq  input  1  branch comparator: operands equal.
- BrLT  input  1  branch comparator: rs1 < rs2 (signedness set by BrUn).
- mem_ready  input  1  unified memory port completed the current request this cycle.
- mem_req  output  1  request on the unified memory port.
- mem_we  output  1  request is a write (store).
- ir_we  output  1  load the instruction register from memory read data.
- pc_we  output  1  update the PC.
- PCSel  output  1  PC source: 0 = PC+4, 1 = ALU result.
- RegWEn  output  1  register file write enable.
- BrUn  output  1  unsigned branch compare.
- state  output  3  current FSM state, for debug.
- retire  output  1  one-cycle pulse per completed instruction.
- illegal  output  1  sticky flag: undecodable instruction.

Function
REQ-002 The block SHALL implement a Moore FSM with these state encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Encodings 5 and 6 SHALL go to FETCH on the next edge.
REQ-003 On the DECODE edge, the block SHALL capture opcode and funct3 into internal registers. All later decisions SHALL use these captured values.
REQ-004 FETCH behaviour:
- mem_req=1, mem_we=0.
- ir_we = mem_ready.
- If mem_ready=1, go to DECODE; otherwise stay in FETCH.
REQ-005 DECODE SHALL last exactly 1 cycle and then go to EXEC. If the captured opcode is not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}, it SHALL go to TRAP instead.
REQ-006 EXEC SHALL last exactly 1 cycle, with transitions by class:
- Load (0000011) and store (0100011): go to MEM.
- Branch (1100011): go to FETCH.
- All other legal opcodes: go to WB.
REQ-007 Branch behaviour in EXEC:
- pc_we=1.
- PCSel = taken, evaluated combinationally from BrEq/BrLT in that cycle.
- taken is defined per funct3: 000 BrEq; 001 !BrEq; 100 BrLT; 101 !BrLT; 110 BrLT; 111 !BrLT.
- funct3 010 or 011: go to TRAP with pc_we=0.
REQ-008 BrUn SHALL equal captured funct3[1] while in EXEC with a branch opcode, and 0 otherwise.
REQ-009 MEM behaviour:
- mem_req=1; mem_we=1 for stores, 0 for loads.
- Hold in MEM until mem_ready=1.
- Load: then go to WB.
- Store: assert pc_we=1, PCSel=0 in the mem_ready cycle, then go to FETCH.
REQ-010 WB SHALL last exactly 1 cycle with RegWEn=1 and pc_we=1, then go to FETCH. PCSel=1 for JAL/JALR and 0 for all other opcodes.
REQ-011 retire SHALL equal pc_we in every cycle, so exactly one pulse is produced per instruction.
REQ-012 TRAP SHALL be absorbing until reset, with these values:
- illegal=1.
- mem_req, mem_we, ir_we, pc_we, RegWEn and retire all 0.
REQ-013 Every output not explicitly asserted in the current state SHALL be 0.
REQ-014 Latency with mem_ready tied high SHALL be:
- ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
- Load: 5 cycles.
- Store: 4 cycles.
- Branch: 3 cycles.
Each memory wait cycle SHALL add exactly 1 cycle.
REQ-015 A mem_ready pulse outside FETCH or MEM SHALL be ignored.
REQ-016 mem_req SHALL never deassert before mem_ready is seen.

Reset
REQ-017 While rst_n=0, asynchronously:
- state=FETCH.
- illegal=0.
- Captured opcode/funct3 = 0.
- All outputs 0, including mem_req; the FETCH decode is masked while reset is asserted.
REQ-018 On the first rising edge with rst_n=1, the FSM SHALL be in FETCH with mem_req=1. Reset asserted in any state, including TRAP or mid-MEM, SHALL abandon the operation with no pc_we or RegWEn pulse.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- ADD (opcode 0110011), mem_ready=1 -> states 0,1,2,4,0; RegWEn and pc_we high only in WB; PCSel=0; one retire pulse.
- LW, mem_ready delayed 3 cycles in both FETCH and MEM -> 11 cycles total; mem_we=0 throughout; ir_we for one cycle; RegWEn in WB.
- BLTU (funct3 110), BrLT=1 -> in EXEC: BrUn=1, PCSel=1, pc_we=1; next state FETCH; RegWEn never asserted.
- BGE (funct3 101), BrLT=1 -> PCSel=0, pc_we=1 in EXEC.
- Opcode 1111111 -> DECODE then TRAP; illegal=1 persists; mem_req stays 0 until rst_n low, then FETCH resumes.
- SW, rst_n dropped during MEM wait -> outputs 0 immediately; pc_we never pulses; FETCH with mem_req=1 after release.
